// File: rtl/data_memory_pkg.sv
// Shared types for the byte-enable data memory and its dump/clear engine.
package data_memory_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef enum logic {
    DMA_DUMP  = 1'b0,
    DMA_CLEAR = 1'b1
  } dma_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    CLEAR,
    DONE
  } dma_state_e;

endpackage

// File: rtl/bytemem_array.sv
// NB-lane word storage: one synchronous byte-enable write port, two async read ports.
module bytemem_array #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 256,
  localparam int unsigned NB     = DATA_W / 8,
  localparam int unsigned IW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic [NB-1:0]     we_i,
  input  logic [IW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IW-1:0]     raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [IW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < int'(NB); k++) begin
      if (we_i[k]) begin
        r_mem[waddr_i][k*8 +: 8] <= wdata_i[k*8 +: 8];
      end
    end
  end

  assign rdata_a_o = r_mem[raddr_a_i];
  assign rdata_b_o = r_mem[raddr_b_i];

endmodule

// File: rtl/data_memory_dma.sv
// Core-facing byte-enable data memory with a sequential engine that streams
// a word range out over valid/ready or zero-fills a range.
module data_memory_dma
  import data_memory_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 256,
  localparam int unsigned NB     = DATA_W / 8,
  localparam int unsigned IW     = $clog2(DEPTH),
  localparam int unsigned OFF    = $clog2(NB),
  localparam int unsigned RW     = IW + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NB-1:0]     we_a_i,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic [DATA_W-1:0] data_a_i,
  output logic [DATA_W-1:0] data_a_o,
  input  logic              cmd_start_i,
  input  logic              cmd_mode_i,
  input  logic [IW-1:0]     cmd_base_i,
  input  logic [RW-1:0]     cmd_count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [DATA_W-1:0] dump_data_o,
  output logic [ADDR_W-1:0] dump_addr_o,
  output logic              dump_last_o
);

  dma_state_e        r_state;
  dma_state_e        w_next;
  logic [IW-1:0]     r_ptr;
  logic [RW-1:0]     r_rem;
  logic              r_busy;
  logic              r_done;
  logic              r_valid;
  logic              r_last;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_addr;

  logic              w_eng_we;
  logic [IW-1:0]     w_core_idx;
  logic [NB-1:0]     w_we;
  logic [IW-1:0]     w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rd_b;
  logic              w_unused_addr;

  assign w_core_idx    = addr_a_i[OFF+IW-1:OFF];
  assign w_unused_addr = ^{addr_a_i[ADDR_W-1:OFF+IW], addr_a_i[OFF-1:0]};

  // Engine owns the write port for the whole CLEAR; core writes are dropped.
  assign w_we    = w_eng_we ? {NB{1'b1}} : we_a_i;
  assign w_waddr = w_eng_we ? r_ptr      : w_core_idx;
  assign w_wdata = w_eng_we ? '0         : data_a_i;

  bytemem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk_i     (clk_i),
    .we_i      (w_we),
    .waddr_i   (w_waddr),
    .wdata_i   (w_wdata),
    .raddr_a_i (w_core_idx),
    .rdata_a_o (data_a_o),
    .raddr_b_i (r_ptr),
    .rdata_b_o (w_rd_b)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_eng_we = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_start_i) begin
          if (cmd_count_i == '0)                        w_next = DONE;
          else if (dma_mode_e'(cmd_mode_i) == DMA_CLEAR) w_next = CLEAR;
          else                                           w_next = LOAD;
        end
      end
      LOAD: w_next = SEND;
      SEND: begin
        if (dump_ready_i) w_next = r_last ? DONE : LOAD;
      end
      CLEAR: begin
        w_eng_we = 1'b1;
        if (r_rem == RW'(1)) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_addr  <= '0;
      r_ptr   <= '0;
      r_rem   <= '0;
    end else begin
      r_busy  <= (w_next != IDLE);
      r_done  <= (w_next == DONE);
      r_valid <= (w_next == SEND);
      case (r_state)
        IDLE: begin
          if (cmd_start_i) begin
            r_ptr <= cmd_base_i;
            r_rem <= cmd_count_i;
          end
        end
        LOAD: begin
          r_data <= w_rd_b;
          r_addr <= ADDR_W'(r_ptr) << OFF;
          r_last <= (r_rem == RW'(1));
        end
        SEND: begin
          if (dump_ready_i) begin
            r_last <= 1'b0;
            if (!r_last) begin
              r_ptr <= r_ptr + IW'(1);
              r_rem <= r_rem - RW'(1);
            end
          end
        end
        CLEAR: begin
          r_ptr <= r_ptr + IW'(1);
          r_rem <= r_rem - RW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign dump_valid_o = r_valid;
  assign dump_last_o  = r_last;
  assign dump_data_o  = r_data;
  assign dump_addr_o  = r_addr;

endmodule

// File: tb/tb_data_memory_dma.sv
// Self-checking bench for data_memory_dma: vector table, directed engine sequences,
// and randomized traffic against a word-array reference model.
module tb_data_memory_dma;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [3:0]  we_a_i;
  logic [31:0] addr_a_i, data_a_i, data_a_o;
  logic        cmd_start_i, cmd_mode_i;
  logic [7:0]  cmd_base_i;
  logic [8:0]  cmd_count_i;
  logic        busy_o, done_o, dump_valid_o, dump_ready_i, dump_last_o;
  logic [31:0] dump_data_o, dump_addr_o;

  int tests = 0;
  int failed = 0;

  logic [31:0] mem_m [DEPTH];

  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [7];

  data_memory_dma #(.DATA_W(32), .DEPTH(256)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .we_a_i       (we_a_i),
    .addr_a_i     (addr_a_i),
    .data_a_i     (data_a_i),
    .data_a_o     (data_a_o),
    .cmd_start_i  (cmd_start_i),
    .cmd_mode_i   (cmd_mode_i),
    .cmd_base_i   (cmd_base_i),
    .cmd_count_i  (cmd_count_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .dump_valid_o (dump_valid_o),
    .dump_ready_i (dump_ready_i),
    .dump_data_o  (dump_data_o),
    .dump_addr_o  (dump_addr_o),
    .dump_last_o  (dump_last_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void mwrite(input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
    int idx;
    idx = int'(a[9:2]);
    for (int k = 0; k < 4; k++) if (we[k]) mem_m[idx][k*8 +: 8] = d[k*8 +: 8];
  endfunction

  task automatic core_write(input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
    we_a_i = we; addr_a_i = a; data_a_i = d;
    tick();
    mwrite(we, a, d);
    we_a_i = 4'h0;
  endtask

  task automatic start_cmd(input logic mode, input int base, input int cnt);
    cmd_start_i = 1'b1; cmd_mode_i = mode;
    cmd_base_i = 8'(base); cmd_count_i = 9'(cnt);
    tick();
    cmd_start_i = 1'b0;
  endtask

  // Read every word through the core port and compare with the model.
  task automatic check_mem(input string nm);
    int bad;
    int first;
    bad = 0; first = -1;
    we_a_i = 4'h0;
    for (int i = 0; i < DEPTH; i++) begin
      addr_a_i = 32'(i) << 2;
      #1;
      if (data_a_o !== mem_m[i]) begin
        if (bad == 0) first = i;
        bad++;
      end
    end
    tests++;
    if (bad != 0) begin
      failed++;
      $display("FAIL %s: %0d words wrong, first word %0d got %h expected %h",
               nm, bad, first, dut.data_a_o, mem_m[first]);
    end
  endtask

  // Drive ready and score beats; expected words are the model at command time.
  task automatic collect(input int base, input int cnt, input int stall, input bit poke, output int cyc);
    logic [31:0] ed[$];
    int beats, wcnt;
    beats = 0; wcnt = 0; cyc = 0;
    for (int i = 0; i < cnt; i++) ed.push_back(mem_m[(base + i) % DEPTH]);
    while (beats < cnt && cyc < 4000) begin
      int idx;
      logic rdy;
      idx = (base + beats) % DEPTH;
      if (stall < 0) rdy = dump_valid_o && ($urandom_range(0, 2) != 0);
      else           rdy = dump_valid_o && (wcnt >= stall);
      dump_ready_i = rdy;
      if (dump_valid_o) begin
        chk("dump_data", dump_data_o, ed[beats]);
        chk("dump_addr", dump_addr_o, 32'(idx) << 2);
        chk("dump_last", 32'(dump_last_o), 32'(beats == cnt - 1));
        if (rdy) begin
          beats++; wcnt = 0;
        end else begin
          wcnt++;
          if (poke) begin
            we_a_i = 4'hF; addr_a_i = 32'(idx) << 2; data_a_i = $urandom;
          end
        end
      end
      tick();
      cyc++;
      if (we_a_i != 4'h0) begin
        mwrite(we_a_i, addr_a_i, data_a_i);
        we_a_i = 4'h0;
      end
    end
    dump_ready_i = 1'b0;
    chk("dump_beats_before_timeout", 32'(beats), 32'(cnt));
    chk("dump_done_pulse", 32'(done_o), 32'd1);
    chk("dump_valid_after_last", 32'(dump_valid_o), 32'd0);
    tick();
    chk("dump_done_one_cycle", 32'(done_o), 32'd0);
    chk("dump_busy_after_done", 32'(busy_o), 32'd0);
  endtask

  // Zero-fill with core writes hammering either a fixed or a random word.
  task automatic run_clear(input int base, input int cnt, input int poke_word);
    start_cmd(1'b1, base, cnt);
    chk("clear_busy", 32'(busy_o), 32'd1);
    for (int k = 0; k < cnt; k++) begin
      chk("clear_done_early", 32'(done_o), 32'd0);
      we_a_i   = 4'hF;
      addr_a_i = (poke_word < 0) ? $urandom : 32'(poke_word) << 2;
      data_a_i = 32'hFFFF_FFFF;
      tick();
    end
    we_a_i = 4'h0;
    chk("clear_done_pulse", 32'(done_o), 32'd1);
    tick();
    chk("clear_done_one_cycle", 32'(done_o), 32'd0);
    chk("clear_busy_after", 32'(busy_o), 32'd0);
    for (int i = 0; i < cnt; i++) mem_m[(base + i) % DEPTH] = 32'h0;
    check_mem("clear_mem");
  endtask

  initial begin
    int cyc;
    vecs[0] = '{4'hF, 32'h0000_0010, 32'hAABB_CCDD, 32'h0000_0010, 32'hAABB_CCDD};
    vecs[1] = '{4'h2, 32'h0000_0010, 32'h0000_1100, 32'h0000_0010, 32'hAABB_11DD};
    vecs[2] = '{4'h8, 32'h0000_0013, 32'h5500_0000, 32'h0000_0010, 32'h55BB_11DD};
    vecs[3] = '{4'hF, 32'h0000_0410, 32'h1234_5678, 32'h0000_0010, 32'h1234_5678};
    vecs[4] = '{4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0010, 32'h1234_5678};
    vecs[5] = '{4'hF, 32'h0000_03FC, 32'hCAFE_F00D, 32'hF000_03FF, 32'hCAFE_F00D};
    vecs[6] = '{4'h5, 32'h0000_03FC, 32'h1122_3344, 32'h0000_03FC, 32'hCA22_F044};

    rst_i = 1'b1; we_a_i = '0; addr_a_i = '0; data_a_i = '0;
    cmd_start_i = 1'b0; cmd_mode_i = 1'b0; cmd_base_i = '0; cmd_count_i = '0;
    dump_ready_i = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_valid", 32'(dump_valid_o), 32'd0);
    chk("rst_last", 32'(dump_last_o), 32'd0);
    chk("rst_data", dump_data_o, 32'd0);
    chk("rst_addr", dump_addr_o, 32'd0);
    rst_i = 1'b0;

    for (int i = 0; i < DEPTH; i++) core_write(4'hF, 32'(i) << 2, $urandom);

    // Core port vector table.
    for (int v = 0; v < 7; v++) begin
      core_write(vecs[v].we, vecs[v].addr, vecs[v].wdata);
      addr_a_i = vecs[v].raddr;
      #1;
      chk($sformatf("vec%0d", v), data_a_o, vecs[v].exp);
    end

    // Dump of words 4..6 at full ready: one beat every two cycles.
    core_write(4'hF, 32'h14, 32'h0101_0101);
    core_write(4'hF, 32'h18, 32'h0202_0202);
    start_cmd(1'b0, 4, 3);
    chk("dump_first_valid_latency", 32'(dump_valid_o), 32'd0);
    chk("dump_busy", 32'(busy_o), 32'd1);
    collect(4, 3, 0, 1'b0, cyc);
    chk("dump_full_rate_cycles", 32'(cyc), 32'd6);

    // Wrapping dump with long stalls and core writes to the held word.
    start_cmd(1'b0, 255, 2);
    collect(255, 2, 5, 1'b1, cyc);
    check_mem("mem_after_stalled_dump");

    run_clear(10, 4, 11);

    // Zero-count commands and a start issued while busy.
    start_cmd(1'b0, 5, 0);
    chk("zero_dump_done", 32'(done_o), 32'd1);
    chk("zero_dump_valid", 32'(dump_valid_o), 32'd0);
    tick();
    chk("zero_dump_done_off", 32'(done_o), 32'd0);
    chk("zero_dump_busy_off", 32'(busy_o), 32'd0);
    start_cmd(1'b1, 5, 0);
    chk("zero_clear_done", 32'(done_o), 32'd1);
    tick();
    chk("zero_clear_done_off", 32'(done_o), 32'd0);
    check_mem("zero_count_mem");
    start_cmd(1'b0, 20, 2);
    cmd_start_i = 1'b1; cmd_mode_i = 1'b1; cmd_base_i = 8'd20; cmd_count_i = 9'd2;
    tick();
    cmd_start_i = 1'b0;
    collect(20, 2, 0, 1'b0, cyc);
    check_mem("start_while_busy_mem");

    // Reset during a dump after one accepted beat.
    start_cmd(1'b0, 4, 3);
    dump_ready_i = 1'b1;
    tick();
    tick();
    dump_ready_i = 1'b0;
    tick();
    chk("pre_reset_valid", 32'(dump_valid_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("mid_rst_valid", 32'(dump_valid_o), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_done", 32'(done_o), 32'd0);
    chk("mid_rst_last", 32'(dump_last_o), 32'd0);
    check_mem("mid_rst_mem");
    start_cmd(1'b0, 4, 3);
    collect(4, 3, 0, 1'b0, cyc);
    chk("restart_cycles", 32'(cyc), 32'd6);

    // Random core traffic against the model.
    for (int n = 0; n < 200; n++) begin
      core_write(4'($urandom_range(0, 15)), $urandom, $urandom);
      addr_a_i = $urandom;
      #1;
      chk("rand_core_read", data_a_o, mem_m[int'(addr_a_i[9:2])]);
    end

    // Random dumps and clears.
    for (int n = 0; n < 10; n++) begin
      int b, c;
      b = $urandom_range(0, 255); c = $urandom_range(1, 8);
      start_cmd(1'b0, b, c);
      collect(b, c, -1, 1'b0, cyc);
    end
    for (int n = 0; n < 5; n++) run_clear($urandom_range(0, 255), $urandom_range(1, 8), -1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
